// File: rtl/seq_mult_arbiter.sv
// seq_mult_arbiter
//   Shares one sequential multiplier between NREQ requesters in round-robin order.
//   The winner's operands are latched and the multiplier is started. When the
//   multiplier reports rdy, the product goes back to the winner with a one-cycle ack.
//   If rdy never arrives within TIMEOUT wait cycles, the operation is forced to
//   complete with err=1 and a zero product.
//
// Ports
//   clk      in   1         clock, everything on posedge
//   reset    in   1         synchronous, active-high
//   req      in   NREQ      request lines, held with operands until ack
//   a_in     in   NREQ*W    operand a per requester, slice i = a_in[i*W +: W]
//   b_in     in   NREQ*W    operand b per requester, same slicing
//   ack      out  NREQ      one-hot completion pulse
//   p_out    out  2*W       product, held until next ack
//   err      out  1         timeout flag, valid with ack
//   busy     out  1         high whenever not IDLE
//   gnt_id   out  IDW       requester currently served
//   m_start  out  1         start pulse (drives the multiplier reset)
//   m_a,m_b  out  W         operands to the multiplier
//   m_p      in   2*W       multiplier product
//   m_rdy    in   1         multiplier ready
module seq_mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  a_in,
  input  logic [NREQ*WIDTH-1:0]  b_in,
  output logic [NREQ-1:0]        ack,
  output logic [2*WIDTH-1:0]     p_out,
  output logic                   err,
  output logic                   busy,
  output logic [IDW-1:0]         gnt_id,
  output logic                   m_start,
  output logic [WIDTH-1:0]       m_a,
  output logic [WIDTH-1:0]       m_b,
  input  logic [2*WIDTH-1:0]     m_p,
  input  logic                   m_rdy
);

  // One extra count value keeps the width non-zero for tiny TIMEOUT values.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t               state_q;
  logic [NREQ-1:0]      ack_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 err_q;
  logic                 busy_q;
  logic [IDW-1:0]       gntId_q;
  logic                 start_q;
  logic [WIDTH-1:0]     opA_q;
  logic [WIDTH-1:0]     opB_q;
  logic [IDW-1:0]       last_q;
  logic [CW-1:0]        waitCnt_q;

  logic [IDW-1:0]       winId_d;
  logic                 winFound_d;
  logic [IDW-1:0]       candId;

  // Round-robin pick: scan last+1, last+2, ... wrapping at NREQ, so the most
  // recently served requester is always considered last.
  always_comb begin
    winFound_d = 1'b0;
    winId_d    = '0;
    candId     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      candId = IDW'((int'(last_q) + k) % NREQ);
      if (!winFound_d && req[candId]) begin
        winFound_d = 1'b1;
        winId_d    = candId;
      end
    end
  end

  // Controller with every output registered. The ack is set on the transition
  // into DONE so that it is high exactly during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      prod_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      gntId_q   <= '0;
      start_q   <= 1'b0;
      opA_q     <= '0;
      opB_q     <= '0;
      last_q    <= IDW'(NREQ - 1);
      waitCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winFound_d) begin
            opA_q   <= a_in[int'(winId_d)*WIDTH +: WIDTH];
            opB_q   <= b_in[int'(winId_d)*WIDTH +: WIDTH];
            gntId_q <= winId_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          // rdy is ignored here: it may still be high from the previous product.
          start_q   <= 1'b0;
          waitCnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (m_rdy) begin
            prod_q          <= m_p;
            err_q           <= 1'b0;
            ack_q           <= '0;
            ack_q[gntId_q]  <= 1'b1;
            state_q         <= DONE;
          end else if (waitCnt_q == CW'(TIMEOUT - 1)) begin
            prod_q          <= '0;
            err_q           <= 1'b1;
            ack_q           <= '0;
            ack_q[gntId_q]  <= 1'b1;
            state_q         <= DONE;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        DONE: begin
          ack_q   <= '0;
          last_q  <= gntId_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign p_out   = prod_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign gnt_id  = gntId_q;
  assign m_start = start_q;
  assign m_a     = opA_q;
  assign m_b     = opB_q;

endmodule
